// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - state encoding shared by the trigger sequencer and its bench
package sync_pkg;

  // Scenario FSM states; codes 6 and 7 are never entered and fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_FIRE     = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [2:0] CODE_IDLE     = 3'd0;
  localparam logic [2:0] CODE_ARMED    = 3'd1;
  localparam logic [2:0] CODE_DELAY    = 3'd2;
  localparam logic [2:0] CODE_FIRE     = 3'd3;
  localparam logic [2:0] CODE_WAIT_RDY = 3'd4;
  localparam logic [2:0] CODE_DONE     = 3'd5;

  // Width of the fixed-size configuration fields (pulse width, trigger limit).
  localparam int CFG16_W = 16;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser, level debouncer and rising-edge pulse
module sync_debounce #(
  parameter int DEB_CYC = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  // Synchronise the raw input, then only adopt a new level after DEB_CYC
  // consecutive samples disagree with the current one; flag 0->1 adoptions.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      rise       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEB_CYC - 1)) begin
        level      <= sync2;
        rise       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_trigger_seq.sv
// rtl/sync_trigger_seq.sv - fast-gate driven multi-channel trigger sequencer
module sync_trigger_seq
  import sync_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int DEB_CYC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_signal,
  input  logic              fg_signal,
  input  logic [N_CH-1:0]   detector_ready,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_max,
  input  logic [N_CH-1:0]   cfg_mask,
  output logic [N_CH-1:0]   output_trigger,
  output logic [2:0]        scenario_state,
  output logic [CNT_W-1:0]  trigger_count,
  output logic [CNT_W-1:0]  missed_count
);

  state_t               state;
  logic                 start_lvl;
  logic                 start_rise;
  logic                 fg_lvl;
  logic                 fg_rise;
  logic                 deb_unused;

  logic [CNT_W-1:0]     delay_q;
  logic [CFG16_W-1:0]   width_q;
  logic [CFG16_W-1:0]   max_q;
  logic [N_CH-1:0]      mask_q;
  logic [CNT_W-1:0]     dly_cnt;
  logic [CFG16_W-1:0]   wid_cnt;

  logic [N_CH-1:0]      fire_vec;
  logic                 all_ready;
  logic                 at_max;
  logic                 fg_missed;
  logic [CNT_W-1:0]     missed_fg;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sync_debounce #(.DEB_CYC(DEB_CYC)) u_start_deb (
    .clock    (clock),
    .reset    (reset),
    .async_in (start_signal),
    .level    (start_lvl),
    .rise     (start_rise)
  );

  sync_debounce #(.DEB_CYC(DEB_CYC)) u_fg_deb (
    .clock    (clock),
    .reset    (reset),
    .async_in (fg_signal),
    .level    (fg_lvl),
    .rise     (fg_rise)
  );

  // The window is governed by the start level and gating by the fg edge only.
  assign deb_unused = ^{start_rise, fg_lvl};

  assign scenario_state = state;

  // Channel selection and window bookkeeping derived from latched config.
  always_comb begin
    fire_vec  = mask_q & detector_ready;
    all_ready = ((detector_ready & mask_q) == mask_q);
    at_max    = (max_q != '0) && (trigger_count == CNT_W'(max_q));
    fg_missed = fg_rise && ((state == ST_DELAY) || (state == ST_FIRE) ||
                            (state == ST_WAIT_RDY));
    missed_fg = fg_missed ? sat_inc(missed_count) : missed_count;
  end

  // Scenario FSM: arm on start, delay from fg edge, fire pulse, wait for
  // detectors to recover, stop after cfg_max triggers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      output_trigger <= '0;
      trigger_count  <= '0;
      missed_count   <= '0;
      delay_q        <= '0;
      width_q        <= '0;
      max_q          <= '0;
      mask_q         <= '0;
      dly_cnt        <= '0;
      wid_cnt        <= '0;
    end else begin
      missed_count <= missed_fg;
      case (state)
        ST_IDLE: begin
          output_trigger <= '0;
          if (start_lvl) begin
            state         <= ST_ARMED;
            delay_q       <= cfg_delay;
            width_q       <= cfg_width;
            max_q         <= cfg_max;
            mask_q        <= cfg_mask;
            trigger_count <= '0;
            missed_count  <= '0;
          end
        end
        ST_ARMED: begin
          output_trigger <= '0;
          if (!start_lvl) begin
            state <= ST_IDLE;
          end else if (fg_rise) begin
            state   <= ST_DELAY;
            dly_cnt <= delay_q;
          end
        end
        ST_DELAY: begin
          output_trigger <= '0;
          if (!start_lvl) begin
            state <= ST_IDLE;
          end else if (dly_cnt <= CNT_W'(1)) begin
            state          <= ST_FIRE;
            output_trigger <= fire_vec;
            wid_cnt        <= width_q;
            if (|fire_vec) begin
              trigger_count <= sat_inc(trigger_count);
            end else begin
              missed_count <= sat_inc(missed_fg);
            end
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end
        ST_FIRE: begin
          // The pulse always runs to completion, even if start has dropped.
          if (wid_cnt <= CFG16_W'(1)) begin
            output_trigger <= '0;
            state          <= start_lvl ? ST_WAIT_RDY : ST_IDLE;
          end else begin
            wid_cnt <= wid_cnt - CFG16_W'(1);
          end
        end
        ST_WAIT_RDY: begin
          output_trigger <= '0;
          if (!start_lvl) begin
            state <= ST_IDLE;
          end else if (at_max) begin
            state <= ST_DONE;
          end else if (all_ready) begin
            state <= ST_ARMED;
          end
        end
        ST_DONE: begin
          output_trigger <= '0;
          if (!start_lvl) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          output_trigger <= '0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
